led_mode_ctrl: RTL and testbench

Board-level LED controller for the three-LED blinky target. It takes one raw push-button, debounces it, and uses each press to step a mode state machine through OFF, COUNT, CHASE and BREATHE. It then drives the active-low `io_led[2:0]` pins with a tick-paced pattern or a PWM-dimmed ramp. It replaces the free-running counter-to-LED mapping as the top-level LED source.

---
 rtl/led_ctrl_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/led_mode_ctrl.sv | 127 ++++++++++++
 tb/tb_led_mode_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED mode controller.
package led_ctrl_pkg;

  // Modes in press order; the encoding is what appears on the mode output.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_COUNT   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam mode_e      MODE_RESET  = MODE_COUNT;
  // Pins are active-low, so all ones means every LED is dark.
  localparam logic [2:0] LED_ALL_OFF = 3'b111;

  // Press sequence: OFF -> COUNT -> CHASE -> BREATHE -> OFF.
  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    unique case (m)
      MODE_OFF:     n = MODE_COUNT;
      MODE_COUNT:   n = MODE_CHASE;
      MODE_CHASE:   n = MODE_BREATHE;
      default:      n = MODE_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, level debouncer and a
// single-cycle press pulse on each accepted press.
//
// Handshake: press is a pure strobe (no ready). It is high for exactly one
// clk cycle when the debounced level flips from released (1) to pressed (0);
// the consumer must act in that cycle. Releases and held buttons never strobe.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounce: count consecutive cycles where the synchronized input disagrees
  // with the accepted level; the cycle that would bring the count to
  // DEBOUNCE_CYCLES flips the level instead and clears the counter.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer and debounce state; everything idles in the released state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Top-level LED source: debounced button steps a mode FSM, which selects a
// tick-paced counter/chase pattern or a PWM breathing ramp on active-low pins.
module led_mode_ctrl #(
  parameter int TICK_DIV        = 3_000_000,
  parameter int DEBOUNCE_CYCLES = 120_000,
  parameter int PWM_BITS        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  output logic [2:0] io_led,
  output logic [1:0] mode
);

  import led_ctrl_pkg::*;

  localparam int                  TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic                press;
  logic                tick;
  logic [2:0]          led_on;

  mode_e               mode_q, mode_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]          step_q, step_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_up_q, dir_up_d;
  logic [2:0]          io_led_q, io_led_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .press (press)
  );

  // Next state: a press changes mode and restarts all pacing (any coincident
  // tick is dropped); otherwise a tick advances the active pattern.
  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    mode_d     = mode_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    step_d     = step_q;
    duty_d     = duty_q;
    dir_up_d   = dir_up_q;
    pwm_d      = pwm_q + PWM_ONE;
    if (press) begin
      mode_d     = next_mode(mode_q);
      tick_cnt_d = '0;
      step_d     = '0;
      duty_d     = '0;
      dir_up_d   = 1'b1;
    end else if (tick) begin
      unique case (mode_q)
        MODE_COUNT: step_d = step_q + 3'd1;
        MODE_CHASE: step_d = (step_q == 3'd2) ? 3'd0 : step_q + 3'd1;
        MODE_BREATHE: begin
          // Triangle ramp: each end value lasts one tick, then turn around.
          if (dir_up_q) begin
            if (duty_q == DUTY_MAX) begin
              dir_up_d = 1'b0;
              duty_d   = duty_q - PWM_ONE;
            end else begin
              duty_d = duty_q + PWM_ONE;
            end
          end else begin
            if (duty_q == '0) begin
              dir_up_d = 1'b1;
              duty_d   = PWM_ONE;
            end else begin
              duty_d = duty_q - PWM_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pattern decode (1 = lit) and inversion for the active-low pins.
  always_comb begin
    led_on = 3'b000;
    unique case (mode_q)
      MODE_OFF:   led_on = 3'b000;
      MODE_COUNT: led_on = step_q;
      MODE_CHASE: begin
        unique case (step_q)
          3'd0:    led_on = 3'b001;
          3'd1:    led_on = 3'b010;
          default: led_on = 3'b100;
        endcase
      end
      default:    led_on = (pwm_q < duty_q) ? 3'b111 : 3'b000;
    endcase
    io_led_d = ~led_on;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_RESET;
      tick_cnt_q <= '0;
      step_q     <= '0;
      pwm_q      <= '0;
      duty_q     <= '0;
      dir_up_q   <= 1'b1;
      io_led_q   <= LED_ALL_OFF;
    end else begin
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      step_q     <= step_d;
      pwm_q      <= pwm_d;
      duty_q     <= duty_d;
      dir_up_q   <= dir_up_d;
      io_led_q   <= io_led_d;
    end
  end

  assign io_led = io_led_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=8, PWM_BITS=2.
module tb_led_mode_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_n;
  logic [2:0] io_led;
  logic [1:0] mode;

  // Expected {mode, io_led} after each clock edge, in order.
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;
  int         checks;
  int         errors;
  int         mon_idx;

  // Reference state: mode, edges since last mode change, edges since reset.
  int m_mode;
  int m_mc;
  int m_g;

  led_mode_ctrl #(
    .TICK_DIV        (4),
    .DEBOUNCE_CYCLES (8),
    .PWM_BITS        (2)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .btn_n  (btn_n),
    .io_led (io_led),
    .mode   (mode)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pin value one edge after a cycle spent in state (md, mc, g).
  function automatic logic [2:0] exp_io(input int md, input int mc, input int g);
    int s;
    int d;
    logic [2:0] r;
    case (md)
      0: r = 3'b111;
      1: begin
        s = (mc / 4) % 8;
        r = ~3'(s);
      end
      2: begin
        s = (mc / 4) % 3;
        r = ~(3'b001 << s);
      end
      default: begin
        s = (mc / 4) % 6;
        d = (s <= 3) ? s : 6 - s;
        r = ((g % 4) < d) ? 3'b000 : 3'b111;
      end
    endcase
    return r;
  endfunction

  // Driver tasks: inputs change at negedge+1, well away from posedge.
  task automatic rst_cyc();
    exp_q.push_back({2'd1, 3'b111});
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic cyc(input logic b, input bit chg);
    logic [2:0] io;
    btn_n = b;
    io = exp_io(m_mode, m_mc, m_g);
    m_g++;
    if (chg) begin
      m_mode = (m_mode + 1) % 4;
      m_mc   = 0;
    end else begin
      m_mc++;
    end
    exp_q.push_back({2'(m_mode), io});
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Button low for 'low' cycles then high for 'high'; with align set, idle
  // first so the press pulse lands in the same cycle as a tick.
  task automatic press(input int low, input int high, input bit align);
    if (align) begin
      while (m_mc % 4 != 1) cyc(1'b1, 1'b0);
    end
    for (int k = 1; k <= low + high; k++) begin
      cyc((k > low) ? 1'b1 : 1'b0, (low >= 8 && k == 11));
    end
  endtask

  // Reset asserted just after an edge; outputs must clear before the next one.
  task automatic mid_reset();
    exp_q.push_back({2'd1, 3'b111});
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    m_mode = 1;
    m_mc   = 0;
    m_g    = 0;
    exp_q.push_back({2'd1, 3'b111});
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: one expected entry per sampled edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_idx++;
      checks++;
      if (mode !== mon_e[4:3]) begin
        errors++;
        $display("FAIL mode #%0d: got %0d expected %0d", mon_idx, mode, mon_e[4:3]);
      end
      checks++;
      if (io_led !== mon_e[2:0]) begin
        errors++;
        $display("FAIL io_led #%0d: got %b expected %b", mon_idx, io_led, mon_e[2:0]);
      end
    end
  end

  // Stimulus
  initial begin
    checks  = 0;
    errors  = 0;
    mon_idx = 0;
    m_mode  = 1;
    m_mc    = 0;
    m_g     = 0;
    reset   = 1'b1;
    btn_n   = 1'b1;
    rst_cyc();
    rst_cyc();
    reset = 1'b0;

    repeat (14) cyc(1'b1, 1'b0);
    mid_reset();
    repeat (36) cyc(1'b1, 1'b0);

    // Held press from COUNT: one event only.
    press(20, 20, 1'b0);

    // Glitch one cycle too short to be accepted.
    press(7, 12, 1'b0);
    checks++;
    if (u_dut.u_debounce.cnt_q !== '0) begin
      errors++;
      $display("FAIL glitch_cnt: got %0d expected 0", u_dut.u_debounce.cnt_q);
    end

    // CHASE -> BREATHE with press on a tick, then a full ramp.
    press(10, 14, 1'b1);
    repeat (24) cyc(1'b1, 1'b0);
    // BREATHE -> OFF with press on a tick; OFF across several ticks.
    press(10, 22, 1'b1);
    // OFF -> COUNT -> CHASE.
    press(10, 20, 1'b0);
    press(10, 20, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
